// File: rtl/window_taps.sv
// Column-tap generator: turns a raster-order binary feature map into vertical
// K-pixel columns {row r-2, row r-1, row r} for the 3x3 binary conv core.
module window_taps #(
    parameter int unsigned K    = 3,
    parameter int unsigned W_L1 = 28,
    parameter int unsigned W_L2 = 26
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         state,
    input  logic         din_valid,
    input  logic         din,
    output logic [K-1:0] taps,
    output logic         tvalid,
    output logic         wvalid,
    output logic [4:0]   col,
    output logic [4:0]   row,
    output logic         done
);

    localparam int unsigned CW = 5;
    localparam int unsigned NB = K - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]    fsm_q, fsm_d;
    logic          ni_sel_q, ni_sel_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [K-1:0]  taps_q, taps_d;
    logic          tvalid_q, tvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          done_q, done_d;

    logic [NB-1:0][W_L1-1:0] lb_q;
    logic [NB-1:0]           lb_tap;
    logic [NB-1:0]           lb_in;
    logic [K-1:0]            col_vec;
    logic [CW-1:0]           ni_m1;
    logic                    col_last;
    logic                    row_last;
    logic                    pix_acc;

    // Tap each line buffer at Ni-1 so it delivers the pixel exactly one row back.
    always_comb begin
        lb_tap = '0;
        lb_in  = '0;
        for (int j = 0; j < int'(NB); j++) begin
            lb_tap[j] = ni_sel_q ? lb_q[j][W_L2-1] : lb_q[j][W_L1-1];
        end
        lb_in[0] = din;
        for (int j = 1; j < int'(NB); j++) begin
            lb_in[j] = lb_tap[j-1];
        end
    end

    assign col_vec  = {lb_tap, din};
    assign ni_m1    = ni_sel_q ? CW'(W_L2 - 1) : CW'(W_L1 - 1);
    assign col_last = (col_cnt_q == ni_m1);
    assign row_last = (row_cnt_q == ni_m1);
    assign pix_acc  = start && din_valid && ((fsm_q == S_FILL) || (fsm_q == S_STREAM));

    // Line buffers: cascaded shift registers advancing only on accepted pixels.
    for (genvar g = 0; g < int'(NB); g++) begin : g_lb
        always_ff @(posedge clk) begin
            if (pix_acc) begin
                lb_q[g] <= {lb_q[g][W_L1-2:0], lb_in[g]};
            end
        end
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        fsm_d     = fsm_q;
        ni_sel_d  = ni_sel_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        taps_d    = taps_q;
        tvalid_d  = 1'b0;
        wvalid_d  = 1'b0;
        done_d    = 1'b0;

        if (!start) begin
            fsm_d     = S_IDLE;
            col_cnt_d = '0;
            row_cnt_d = '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    fsm_d     = S_FILL;
                    ni_sel_d  = state;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
                end
                S_FILL, S_STREAM: begin
                    if (din_valid) begin
                        taps_d = col_vec;
                        col_d  = col_cnt_q;
                        row_d  = row_cnt_q;
                        if (col_last) begin
                            col_cnt_d = '0;
                            row_cnt_d = row_cnt_q + CW'(1);
                        end else begin
                            col_cnt_d = col_cnt_q + CW'(1);
                        end
                        if (fsm_q == S_FILL) begin
                            if (col_last && (row_cnt_q == CW'(K - 2))) begin
                                fsm_d = S_STREAM;
                            end
                        end else begin
                            tvalid_d = 1'b1;
                            wvalid_d = (col_cnt_q >= CW'(K - 1));
                            if (col_last && row_last) begin
                                fsm_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_d = 1'b1;
                    fsm_d  = S_HOLD;
                end
                S_HOLD: begin
                    fsm_d = S_HOLD;
                end
                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q     <= S_IDLE;
            ni_sel_q  <= 1'b0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            taps_q    <= '0;
            tvalid_q  <= 1'b0;
            wvalid_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            ni_sel_q  <= ni_sel_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            taps_q    <= taps_d;
            tvalid_q  <= tvalid_d;
            wvalid_q  <= wvalid_d;
            done_q    <= done_d;
        end
    end

    assign taps   = taps_q;
    assign tvalid = tvalid_q;
    assign wvalid = wvalid_q;
    assign col    = col_q;
    assign row    = row_q;
    assign done   = done_q;

endmodule

// File: tb/tb_window_taps.sv
// Directed + randomized bench for window_taps, checked against an image-array model.
module tb_window_taps;

    localparam int unsigned K    = 3;
    localparam int unsigned W_L1 = 28;
    localparam int unsigned W_L2 = 26;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       state;
    logic       din_valid;
    logic       din;
    logic [2:0] taps;
    logic       tvalid;
    logic       wvalid;
    logic [4:0] col;
    logic [4:0] row;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;

    bit img [0:W_L1-1][0:W_L1-1];

    window_taps #(.K(K), .W_L1(W_L1), .W_L2(W_L2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .state    (state),
        .din_valid(din_valid),
        .din      (din),
        .taps     (taps),
        .tvalid   (tvalid),
        .wvalid   (wvalid),
        .col      (col),
        .row      (row),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_col(input int r, input int c);
        logic [2:0] v;
        v = {img[r-2][c], img[r-1][c], img[r][c]};
        return 32'(v);
    endfunction

    // mode 0: (row^col)&1, mode 1: all ones, otherwise random
    task automatic gen_img(input int mode, input int ni);
        for (int r = 0; r < ni; r++) begin
            for (int c = 0; c < ni; c++) begin
                case (mode)
                    0:       img[r][c] = 1'((r ^ c) & 1);
                    1:       img[r][c] = 1'b1;
                    default: img[r][c] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    endtask

    task automatic start_frame(input logic st);
        state     = st;
        start     = 1'b1;
        din_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Drive pixels 0..stop_at-1 and check every cycle against the image model.
    task automatic send(input int ni, input int gap, input int toggle_at, input int stop_at,
                        output int tv, output int wv, output int first);
        int  idx;
        int  cyc;
        int  r;
        int  c;
        int  pr;
        int  pc;
        bit  v;
        bit  toggled;
        idx = 0; cyc = 0; tv = 0; wv = 0; first = -1; pr = 0; pc = 0; toggled = 1'b0;
        while (idx < stop_at) begin
            v = (gap == 0) || ((cyc % gap) != gap - 1);
            if (idx == toggle_at && !toggled) begin
                state   = ~state;
                toggled = 1'b1;
            end
            r = idx / ni;
            c = idx % ni;
            din_valid = v;
            din       = v ? img[r][c] : 1'($urandom);
            @(posedge clk); #1;
            cyc++;
            chk("done_mid_frame", 32'(done), 32'(0));
            if (v) begin
                chk("tvalid", 32'(tvalid), 32'(r >= 2));
                chk("wvalid", 32'(wvalid), 32'(r >= 2 && c >= 2));
                if (r >= 2) begin
                    chk("taps", 32'(taps), exp_col(r, c));
                    chk("col", 32'(col), 32'(c));
                    chk("row", 32'(row), 32'(r));
                end
                if (tvalid) tv++;
                if (wvalid) wv++;
                if (tvalid && first < 0) first = idx + 1;
                pr = r;
                pc = c;
                idx++;
            end else begin
                chk("tvalid_idle", 32'(tvalid), 32'(0));
                chk("wvalid_idle", 32'(wvalid), 32'(0));
                if (idx > 0 && pr >= 2) begin
                    chk("taps_hold", 32'(taps), exp_col(pr, pc));
                    chk("col_hold", 32'(col), 32'(pc));
                    chk("row_hold", 32'(row), 32'(pr));
                end
            end
        end
        din_valid = 1'b0;
    endtask

    // Done pulse, then extra pixels under a held start must be ignored.
    task automatic check_tail();
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'(1));
        chk("tvalid_at_done", 32'(tvalid), 32'(0));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'(0));
        for (int i = 0; i < 5; i++) begin
            din_valid = 1'b1;
            din       = 1'($urandom);
            @(posedge clk); #1;
            chk("tvalid_after_done", 32'(tvalid), 32'(0));
            chk("no_second_done", 32'(done), 32'(0));
        end
        din_valid = 1'b0;
        start     = 1'b0;
        @(posedge clk); #1;
        chk("done_after_idle", 32'(done), 32'(0));
    endtask

    task automatic full_frame(input logic st, input int mode, input int gap, input int toggle_at);
        int ni;
        int tv;
        int wv;
        int first;
        ni = st ? int'(W_L2) : int'(W_L1);
        gen_img(mode, ni);
        start_frame(st);
        send(ni, gap, toggle_at, ni * ni, tv, wv, first);
        chk("tvalid_count", 32'(tv), 32'(ni * (ni - 2)));
        chk("wvalid_count", 32'(wv), 32'((ni - 2) * (ni - 2)));
        chk("first_tvalid_beat", 32'(first), 32'(2 * ni + 1));
        check_tail();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_taps"}, 32'(taps), 32'(0));
        chk({tag, "_tvalid"}, 32'(tvalid), 32'(0));
        chk({tag, "_wvalid"}, 32'(wvalid), 32'(0));
        chk({tag, "_col"}, 32'(col), 32'(0));
        chk({tag, "_row"}, 32'(row), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
    endtask

    initial begin
        int tv;
        int wv;
        int first;
        rstn = 1'b0; start = 1'b0; state = 1'b0; din_valid = 1'b0; din = 1'b0;
        #12;
        check_reset_vals("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Idle with start low: pixels ignored
        din_valid = 1'b1; din = 1'b1;
        @(posedge clk); #1;
        chk("idle_tvalid", 32'(tvalid), 32'(0));
        din_valid = 1'b0;

        // Layer-1 checkerboard frame
        full_frame(1'b0, 0, 0, -1);
        // Layer-2 all-ones frame
        full_frame(1'b1, 1, 0, -1);
        // Layer-1 checkerboard with every third cycle idle
        full_frame(1'b0, 0, 3, -1);
        // Layer select toggled mid-frame is ignored
        full_frame(1'b0, 0, 0, 300);
        state = 1'b0;

        // Abort by dropping start at pixel 400, then a full frame
        gen_img(0, W_L1);
        start_frame(1'b0);
        send(W_L1, 0, -1, 400, tv, wv, first);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 32'(0));
            chk("abort_no_tvalid", 32'(tvalid), 32'(0));
        end
        full_frame(1'b0, 0, 0, -1);

        // Abort by async reset at pixel 400, then a full frame
        gen_img(0, W_L1);
        start_frame(1'b0);
        send(W_L1, 0, -1, 400, tv, wv, first);
        #2 rstn = 1'b0;
        #1 check_reset_vals("async_rst");
        start = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", 32'(done), 32'(0));
        full_frame(1'b0, 0, 0, -1);

        // Randomized frames on both layers, one with idle gaps
        full_frame(1'b0, 2, 0, -1);
        full_frame(1'b1, 2, 3, -1);
        full_frame(1'b1, 2, 0, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
